// File: rtl/regfile_scoreboard.sv
// Register-busy scoreboard: one busy bit per architectural register r1..r63.
// Gates issue on RAW/WAW hazards and releases registers on commit writes.
module regfile_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [5:0]  issue_rs1,
  input  logic [5:0]  issue_rs2,
  input  logic [5:0]  issue_rs3,
  input  logic [5:0]  issue_rd,
  input  logic [5:0]  issue_rd2,
  output logic        issue_ready,
  input  logic [5:0]  write_rn,
  output logic [63:0] busy_vec,
  output logic [6:0]  inflight,
  output logic        idle,
  output logic        err_spurious
);

  logic [63:0] clr_onehot;
  logic [63:0] eff_busy;
  logic [63:0] set_mask;
  logic [63:0] new_bits;
  logic [63:0] busy_next;
  logic        fire;
  logic        write_act;
  logic        real_clear;
  logic        spurious;
  logic [1:0]  new_cnt;
  logic [6:0]  inflight_next;

  always_comb begin
    clr_onehot = '0;
    if (write_rn != '0) clr_onehot[write_rn] = 1'b1;

    // Same-cycle commit bypass lets a dependent instruction issue back-to-back.
    eff_busy    = busy_vec & ~clr_onehot;
    issue_ready = ~(eff_busy[issue_rs1] | eff_busy[issue_rs2] | eff_busy[issue_rs3] |
                    eff_busy[issue_rd]  | eff_busy[issue_rd2]);
    fire        = issue_valid & issue_ready;

    set_mask = '0;
    if (fire) begin
      set_mask[issue_rd]  = 1'b1;
      set_mask[issue_rd2] = 1'b1;
    end
    set_mask[0] = 1'b0;

    write_act  = (write_rn != '0);
    spurious   = write_act & ~busy_vec[write_rn];
    real_clear = write_act & busy_vec[write_rn] & ~set_mask[write_rn];

    // Count only 0->1 transitions so a re-set of a committing register nets zero.
    new_bits = set_mask & ~busy_vec;
    new_cnt  = {1'b0, new_bits[issue_rd]} +
               {1'b0, new_bits[issue_rd2] & (issue_rd2 != issue_rd)};

    busy_next     = (real_clear ? (busy_vec & ~clr_onehot) : busy_vec) | set_mask;
    inflight_next = inflight + 7'(new_cnt) - 7'(real_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec     <= '0;
      inflight     <= '0;
      err_spurious <= 1'b0;
    end else begin
      busy_vec <= busy_next;
      inflight <= inflight_next;
      if (spurious) err_spurious <= 1'b1;
    end
  end

  assign idle = (inflight == '0);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random
// traffic, checked against an array-based reference model.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [5:0]  issue_rs1, issue_rs2, issue_rs3, issue_rd, issue_rd2;
  logic        issue_ready;
  logic [5:0]  write_rn;
  logic [63:0] busy_vec;
  logic [6:0]  inflight;
  logic        idle;
  logic        err_spurious;

  int total  = 0;
  int passed = 0;

  bit mb[64];
  bit merr;

  regfile_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rs3    (issue_rs3),
    .issue_rd     (issue_rd),
    .issue_rd2    (issue_rd2),
    .issue_ready  (issue_ready),
    .write_rn     (write_rn),
    .busy_vec     (busy_vec),
    .inflight     (inflight),
    .idle         (idle),
    .err_spurious (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mvec();
    logic [63:0] v;
    v = '0;
    for (int i = 1; i < 64; i++) v[i] = mb[i];
    return v;
  endfunction

  function automatic int mcount();
    int n;
    n = 0;
    for (int i = 1; i < 64; i++) n += int'(mb[i]);
    return n;
  endfunction

  function automatic bit mhaz(input logic [5:0] r, input logic [5:0] w);
    return (r != 0) && mb[r] && (r != w);
  endfunction

  function automatic bit mready(input logic [5:0] s1, s2, s3, d, d2, w);
    return !(mhaz(s1, w) || mhaz(s2, w) || mhaz(s3, w) || mhaz(d, w) || mhaz(d2, w));
  endfunction

  task automatic mclear();
    for (int i = 0; i < 64; i++) mb[i] = 1'b0;
    merr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".busy_vec"}, busy_vec, mvec());
    chk({tag, ".inflight"}, 64'(inflight), 64'(mcount()));
    chk({tag, ".idle"}, 64'(idle), 64'(mcount() == 0));
    chk({tag, ".err"}, 64'(err_spurious), 64'(merr));
  endtask

  // Entered just after a posedge; applies one cycle of stimulus and checks it.
  task automatic step(input string tag, input logic v,
                      input logic [5:0] s1, s2, s3, d, d2, w,
                      input bit full_check);
    bit rdy;
    bit fire;
    issue_valid = v;
    issue_rs1 = s1; issue_rs2 = s2; issue_rs3 = s3;
    issue_rd = d;   issue_rd2 = d2; write_rn = w;
    #2;
    rdy = mready(s1, s2, s3, d, d2, w);
    chk({tag, ".ready"}, 64'(issue_ready), 64'(rdy));
    @(posedge clk);
    fire = v && rdy;
    if (w != 0) begin
      if (!mb[w]) merr = 1'b1;
      else mb[w] = 1'b0;
    end
    if (fire) begin
      if (d != 0)  mb[d]  = 1'b1;
      if (d2 != 0) mb[d2] = 1'b1;
    end
    #1;
    if (full_check) check_state(tag);
  endtask

  initial begin
    logic [63:0] exp_v;
    mclear();
    rst_n = 1'b0;
    issue_valid = 1'b0;
    issue_rs1 = 6'd5; issue_rs2 = '0; issue_rs3 = '0;
    issue_rd = '0; issue_rd2 = '0; write_rn = '0;
    #2;
    check_state("reset");
    chk("reset.ready", 64'(issue_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic issue and stall/bypass
    step("iss5", 1, 0, 0, 0, 5, 0, 0, 1);
    exp_v = 64'h20;
    chk("iss5.vec_const", busy_vec, exp_v);
    chk("iss5.cnt_const", 64'(inflight), 64'd1);
    step("stall5", 0, 5, 0, 0, 0, 0, 0, 1);
    step("bypass5", 1, 5, 0, 0, 7, 0, 5, 1);
    exp_v = 64'h80;
    chk("bypass5.vec_const", busy_vec, exp_v);
    step("clr7", 0, 0, 0, 0, 0, 0, 7, 1);

    // Set wins over a same-cycle clear
    step("iss9", 1, 0, 0, 0, 9, 0, 0, 1);
    step("reset9", 1, 0, 0, 0, 9, 0, 9, 1);
    chk("reset9.cnt_const", 64'(inflight), 64'd1);
    step("clr9", 0, 0, 0, 0, 0, 0, 9, 1);

    // Duplicate destinations and successive commits
    step("dup3", 1, 0, 0, 0, 3, 3, 0, 1);
    step("iss10_11", 1, 0, 0, 0, 10, 11, 0, 1);
    chk("iss10_11.cnt_const", 64'(inflight), 64'd3);
    step("clr10", 0, 0, 0, 0, 0, 0, 10, 1);
    step("clr11", 0, 0, 0, 0, 0, 0, 11, 1);
    step("clr3", 0, 0, 0, 0, 0, 0, 3, 1);
    chk("clr3.idle_const", 64'(idle), 64'd1);

    // Spurious commit is sticky; r63 behaves normally
    step("spur20", 0, 0, 0, 0, 0, 0, 20, 1);
    chk("spur20.err_const", 64'(err_spurious), 64'd1);
    step("iss63", 1, 0, 0, 0, 63, 0, 0, 1);
    step("clr63", 0, 0, 0, 0, 0, 0, 63, 1);
    chk("clr63.err_sticky", 64'(err_spurious), 64'd1);

    // Fill all 63 registers with 32 dual-destination fires
    for (int k = 0; k < 32; k++) begin
      logic [5:0] a, b;
      a = 6'(2 * k + 1);
      b = (k == 31) ? 6'd0 : 6'(2 * k + 2);
      step("fill", 1, 0, 0, 0, a, b, 0, 0);
    end
    check_state("full");
    chk("full.cnt_const", 64'(inflight), 64'd63);
    step("full_stall", 1, 0, 0, 0, 0, 40, 0, 1);
    step("full_zero", 1, 0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset with no clock edge
    #1;
    rst_n = 1'b0;
    issue_rs1 = 6'd17; issue_rd = '0; issue_rd2 = '0; write_rn = '0;
    #1;
    mclear();
    check_state("async_rst");
    chk("async_rst.ready", 64'(issue_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic biased toward a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [5:0] s1, s2, s3, d, d2, w;
      int start;
      s1 = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 15));
      s2 = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 15));
      s3 = ($urandom_range(0, 3) != 0) ? 6'd0 : 6'($urandom_range(1, 63));
      d  = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 15));
      d2 = ($urandom_range(0, 2) != 0) ? 6'd0 : 6'($urandom_range(1, 15));
      w  = '0;
      if ($urandom_range(0, 9) == 0) w = 6'($urandom_range(0, 63));
      else if ($urandom_range(0, 2) != 0) begin
        start = $urandom_range(0, 62);
        for (int k = 0; k < 63; k++) begin
          if (w == 0 && mb[((start + k) % 63) + 1]) w = 6'(((start + k) % 63) + 1);
        end
      end
      step("rand", 1'($urandom_range(0, 1)), s1, s2, s3, d, d2, w, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
